// File: rtl/board_clear_ctrl.sv
// board_clear_ctrl
// Line-clear sequencer for the one-bit-per-cell board memory. After a piece
// locks, this block scans rows bottom-up, removes every full row, moves the
// remaining rows down to close the gaps, zero-fills the rows left empty at the
// top and reports how many lines it removed. While busy is high it owns the
// board read/write port.
module board_clear_ctrl #(
    parameter int COLS   = 10,
    parameter int ROWS   = 20,
    parameter int RD_LAT = 1
) (
    input  logic       CLOCK_50,
    input  logic       resetn,
    input  logic       start,
    output logic       busy,
    output logic       done,
    output logic [4:0] lines_cleared,
    output logic [3:0] board_rx,
    output logic [4:0] board_ry,
    input  logic       board_rdata,
    output logic       board_we,
    output logic [3:0] board_wx,
    output logic [4:0] board_wy,
    output logic       board_wdata
);

    // The column counter also counts the read-latency tail of READ, so it
    // must reach COLS+RD_LAT-1. It is never narrower than the column port.
    localparam int CW_RAW = $clog2(COLS + RD_LAT + 1);
    localparam int CW     = (CW_RAW > 4) ? CW_RAW : 4;

    localparam logic [CW-1:0]       COL_ONE     = CW'(1);
    localparam logic [CW-1:0]       COL_LAST_RD = CW'(COLS + RD_LAT - 1);
    localparam logic [CW-1:0]       COL_LAST_WR = CW'(COLS - 1);
    localparam logic [CW-1:0]       COL_RD_END  = CW'(COLS);
    localparam logic signed [5:0]   ROW_TOP     = 6'(ROWS - 1);

    localparam logic [2:0] S_IDLE = 3'd0;
    localparam logic [2:0] S_READ = 3'd1;
    localparam logic [2:0] S_EVAL = 3'd2;
    localparam logic [2:0] S_COPY = 3'd3;
    localparam logic [2:0] S_FILL = 3'd4;
    localparam logic [2:0] S_DONE = 3'd5;

    // A row index is usable while its sign bit is clear; -1 marks "past row 0".
    function automatic logic is_nonneg(input logic signed [5:0] v);
        return ~v[5];
    endfunction

    // Board row address for a signed row index; negative rows map to 0.
    function automatic logic [4:0] row_addr(input logic signed [5:0] v);
        logic [4:0] a_v;
        if (is_nonneg(v)) begin
            a_v = v[4:0];
        end else begin
            a_v = 5'd0;
        end
        return a_v;
    endfunction

    // Select one cell of a buffered row without a variable-width part select.
    function automatic logic row_bit(input logic [COLS-1:0] row, input logic [CW-1:0] idx);
        logic bit_v;
        bit_v = 1'b0;
        for (int i = 0; i < COLS; i++) begin
            if (idx == CW'(i)) begin
                bit_v = row[i];
            end else begin
                bit_v = bit_v;
            end
        end
        return bit_v;
    endfunction

    // State and datapath registers
    logic [2:0]          state_r;
    logic signed [5:0]   src_r;
    logic signed [5:0]   dst_r;
    logic [CW-1:0]       col_r;
    logic [COLS-1:0]     rowbuf_r;
    logic [4:0]          cnt_r;
    logic [4:0]          lines_r;

    // Registered outputs
    logic                busy_r;
    logic                done_r;
    logic [3:0]          rx_r;
    logic [4:0]          ry_r;
    logic                we_r;
    logic [3:0]          wx_r;
    logic [4:0]          wy_r;
    logic                wdata_r;

    // Next-state values
    logic [2:0]          state_s;
    logic signed [5:0]   src_s;
    logic signed [5:0]   dst_s;
    logic [CW-1:0]       col_s;
    logic [COLS-1:0]     rowbuf_s;
    logic [4:0]          cnt_s;
    logic [4:0]          lines_s;
    logic signed [5:0]   src_dec_s;
    logic signed [5:0]   dst_dec_s;

    // Next-output values, derived from the next state so outputs line up with it
    logic                busy_s;
    logic                done_s;
    logic [3:0]          rx_s;
    logic [4:0]          ry_s;
    logic                we_s;
    logic [3:0]          wx_s;
    logic [4:0]          wy_s;
    logic                wdata_s;

    // Sequencer next-state logic: scan, evaluate, compact and fill
    always_comb begin
        state_s   = state_r;
        src_s     = src_r;
        dst_s     = dst_r;
        col_s     = col_r;
        rowbuf_s  = rowbuf_r;
        cnt_s     = cnt_r;
        lines_s   = lines_r;
        src_dec_s = src_r - 6'sd1;
        dst_dec_s = dst_r - 6'sd1;

        case (state_r)
            S_IDLE: begin
                if (start) begin
                    src_s   = ROW_TOP;
                    dst_s   = ROW_TOP;
                    cnt_s   = 5'd0;
                    lines_s = 5'd0;
                    col_s   = '0;
                    state_s = S_READ;
                end else begin
                    state_s = S_IDLE;
                end
            end

            S_READ: begin
                // Data for the address issued k cycles ago lands now.
                for (int i = 0; i < COLS; i++) begin
                    if (col_r == CW'(i + RD_LAT)) begin
                        rowbuf_s[i] = board_rdata;
                    end else begin
                        rowbuf_s[i] = rowbuf_r[i];
                    end
                end
                if (col_r == COL_LAST_RD) begin
                    col_s   = '0;
                    state_s = S_EVAL;
                end else begin
                    col_s   = col_r + COL_ONE;
                end
            end

            S_EVAL: begin
                col_s = '0;
                if (&rowbuf_r) begin
                    // Full row: drop it, keep the write pointer where it is.
                    cnt_s = cnt_r + 5'd1;
                    src_s = src_dec_s;
                    if (is_nonneg(src_dec_s)) begin
                        state_s = S_READ;
                    end else if (is_nonneg(dst_r)) begin
                        state_s = S_FILL;
                    end else begin
                        state_s = S_DONE;
                    end
                end else if (src_r != dst_r) begin
                    // Surviving row above a gap: move it down.
                    state_s = S_COPY;
                end else begin
                    // Surviving row already in place: nothing to write.
                    src_s = src_dec_s;
                    dst_s = dst_dec_s;
                    if (is_nonneg(src_dec_s)) begin
                        state_s = S_READ;
                    end else if (is_nonneg(dst_dec_s) && (cnt_r != 5'd0)) begin
                        state_s = S_FILL;
                    end else begin
                        state_s = S_DONE;
                    end
                end
            end

            S_COPY: begin
                if (col_r == COL_LAST_WR) begin
                    col_s = '0;
                    src_s = src_dec_s;
                    dst_s = dst_dec_s;
                    // A copy only happens after a clear, so the fill is never empty.
                    if (is_nonneg(src_dec_s)) begin
                        state_s = S_READ;
                    end else begin
                        state_s = S_FILL;
                    end
                end else begin
                    col_s = col_r + COL_ONE;
                end
            end

            S_FILL: begin
                if (col_r == COL_LAST_WR) begin
                    col_s = '0;
                    dst_s = dst_dec_s;
                    if (is_nonneg(dst_dec_s)) begin
                        state_s = S_FILL;
                    end else begin
                        state_s = S_DONE;
                    end
                end else begin
                    col_s = col_r + COL_ONE;
                end
            end

            S_DONE: begin
                lines_s = cnt_r;
                state_s = S_IDLE;
            end

            default: begin
                state_s = S_IDLE;
            end
        endcase
    end

    // Board port and status values for the cycle after this edge
    always_comb begin
        busy_s  = (state_s != S_IDLE);
        done_s  = (state_s == S_DONE);
        rx_s    = rx_r;
        ry_s    = ry_r;
        wx_s    = wx_r;
        wy_s    = wy_r;
        we_s    = (state_s == S_COPY) || (state_s == S_FILL);
        wdata_s = 1'b0;

        // Read address advances only on the issue cycles, then holds.
        if ((state_s == S_READ) && (col_s < COL_RD_END)) begin
            rx_s = 4'(col_s);
            ry_s = row_addr(src_s);
        end else begin
            rx_s = rx_r;
            ry_s = ry_r;
        end

        if (we_s) begin
            wx_s = 4'(col_s);
            wy_s = row_addr(dst_s);
            if (state_s == S_COPY) begin
                wdata_s = row_bit(rowbuf_s, col_s);
            end else begin
                wdata_s = 1'b0;
            end
        end else begin
            wx_s    = wx_r;
            wy_s    = wy_r;
            wdata_s = 1'b0;
        end
    end

    // State, datapath and output registers with synchronous active-low reset
    always_ff @(posedge CLOCK_50) begin
        if (!resetn) begin
            state_r  <= S_IDLE;
            src_r    <= ROW_TOP;
            dst_r    <= ROW_TOP;
            col_r    <= '0;
            rowbuf_r <= '0;
            cnt_r    <= 5'd0;
            lines_r  <= 5'd0;
            busy_r   <= 1'b0;
            done_r   <= 1'b0;
            rx_r     <= 4'd0;
            ry_r     <= 5'd0;
            we_r     <= 1'b0;
            wx_r     <= 4'd0;
            wy_r     <= 5'd0;
            wdata_r  <= 1'b0;
        end else begin
            state_r  <= state_s;
            src_r    <= src_s;
            dst_r    <= dst_s;
            col_r    <= col_s;
            rowbuf_r <= rowbuf_s;
            cnt_r    <= cnt_s;
            lines_r  <= lines_s;
            busy_r   <= busy_s;
            done_r   <= done_s;
            rx_r     <= rx_s;
            ry_r     <= ry_s;
            we_r     <= we_s;
            wx_r     <= wx_s;
            wy_r     <= wy_s;
            wdata_r  <= wdata_s;
        end
    end

    assign busy          = busy_r;
    assign done          = done_r;
    assign lines_cleared = lines_r;
    assign board_rx      = rx_r;
    assign board_ry      = ry_r;
    assign board_we      = we_r;
    assign board_wx      = wx_r;
    assign board_wy      = wy_r;
    assign board_wdata   = wdata_r;

endmodule

// File: tb/tb_board_clear_ctrl.sv
// tb_board_clear_ctrl
// Directed bench for board_clear_ctrl: a behavioural board memory with one
// cycle read latency, loaded with hand-built images, checked row by row
// against hand-computed results, pass timing and write counts.
module tb_board_clear_ctrl;

    localparam int COLS = 10;
    localparam int ROWS = 20;

    logic            CLOCK_50 = 1'b0;
    logic            resetn   = 1'b0;
    logic            start    = 1'b0;
    logic            busy;
    logic            done;
    logic [4:0]      lines_cleared;
    logic [3:0]      board_rx;
    logic [4:0]      board_ry;
    logic            board_rdata = 1'b0;
    logic            board_we;
    logic [3:0]      board_wx;
    logic [4:0]      board_wy;
    logic            board_wdata;

    logic [COLS-1:0] mem      [ROWS];
    logic [COLS-1:0] init_img [ROWS];
    logic [COLS-1:0] exp_img  [ROWS];
    logic            load_req  = 1'b0;
    logic            clr_stats = 1'b0;
    int              cyc       = 0;
    int              wr_cnt    = 0;
    int              done_cnt  = 0;
    logic [ROWS-1:0] wr_rows   = '0;

    int              n_checks  = 0;
    int              n_fail    = 0;
    int              last_off  = 0;

    board_clear_ctrl #(.COLS(COLS), .ROWS(ROWS), .RD_LAT(1)) dut (
        .CLOCK_50      (CLOCK_50),
        .resetn        (resetn),
        .start         (start),
        .busy          (busy),
        .done          (done),
        .lines_cleared (lines_cleared),
        .board_rx      (board_rx),
        .board_ry      (board_ry),
        .board_rdata   (board_rdata),
        .board_we      (board_we),
        .board_wx      (board_wx),
        .board_wy      (board_wy),
        .board_wdata   (board_wdata)
    );

    // 50 MHz clock
    always #10 CLOCK_50 = ~CLOCK_50;

    // Board memory (registered read), image loading and write/done bookkeeping
    always @(posedge CLOCK_50) begin
        cyc         <= cyc + 1;
        board_rdata <= mem[board_ry][board_rx];
        if (load_req) begin
            mem <= init_img;
        end else if (board_we) begin
            mem[board_wy][board_wx] <= board_wdata;
        end
        if (clr_stats) begin
            wr_cnt   <= 0;
            done_cnt <= 0;
            wr_rows  <= '0;
        end else begin
            if (board_we) begin
                wr_cnt            <= wr_cnt + 1;
                wr_rows[board_wy] <= 1'b1;
            end
            if (done) begin
                done_cnt <= done_cnt + 1;
            end
        end
    end

    task automatic check_val(input string tag, input int obs, input int exp_v);
        n_checks++;
        if (obs !== exp_v) begin
            n_fail++;
            $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h)", tag, obs, obs, exp_v, exp_v);
        end
    endtask

    task automatic tick();
        @(posedge CLOCK_50);
        #1;
    endtask

    task automatic clear_imgs();
        for (int r = 0; r < ROWS; r++) begin
            init_img[r] = '0;
            exp_img[r]  = '0;
        end
    endtask

    task automatic load_board();
        tick();
        load_req  = 1'b1;
        clr_stats = 1'b1;
        tick();
        load_req  = 1'b0;
        clr_stats = 1'b0;
    endtask

    task automatic check_board(input string tag);
        for (int r = 0; r < ROWS; r++) begin
            check_val($sformatf("%s_row%0d", tag, r), int'(mem[r]), int'(exp_img[r]));
        end
    endtask

    // One clear pass; re_a/re_b are cycle offsets (0 = unused) at which start
    // is pulsed again while busy. last_off receives done's offset from start.
    task automatic run_pass(input string tag, input int re_a, input int re_b);
        int t0;
        bit seen;
        tick();
        start = 1'b1;
        t0    = cyc;
        tick();
        start = 1'b0;
        check_val({tag, "_busy_T+1"}, int'(busy), 1);
        seen     = 1'b0;
        last_off = -1;
        for (int i = 0; i < 600 && !seen; i++) begin
            if (done) begin
                seen     = 1'b1;
                last_off = cyc - t0;
            end else begin
                start = ((cyc - t0) == re_a) || ((cyc - t0) == re_b);
                tick();
            end
        end
        start = 1'b0;
        if (!seen) begin
            check_val({tag, "_done_timeout"}, 0, 1);
        end
        tick();
        check_val({tag, "_busy_after_done"}, int'(busy), 0);
        check_val({tag, "_done_pulses"}, done_cnt, 1);
    endtask

    initial begin
        clear_imgs();
        resetn = 1'b0;
        repeat (3) tick();
        check_val("rst_busy", int'(busy), 0);
        check_val("rst_done", int'(done), 0);
        check_val("rst_lines", int'(lines_cleared), 0);
        check_val("rst_we", int'(board_we), 0);
        check_val("rst_addr", int'({board_rx, board_ry, board_wx, board_wy, board_wdata}), 0);
        resetn = 1'b1;

        // 1: empty board, no clears
        clear_imgs();
        load_board();
        run_pass("s1", 0, 0);
        check_val("s1_done_off", last_off, 241);
        check_val("s1_lines", int'(lines_cleared), 0);
        check_val("s1_writes", wr_cnt, 0);

        // 2: bottom row full, row above partially filled
        clear_imgs();
        init_img[19] = 10'h3FF;
        init_img[18] = 10'h01F;
        exp_img[19]  = 10'h01F;
        load_board();
        run_pass("s2", 0, 0);
        check_val("s2_done_off", last_off, 441);
        check_val("s2_lines", int'(lines_cleared), 1);
        check_val("s2_writes", wr_cnt, 200);
        check_board("s2");

        // 3: four full rows at the bottom
        clear_imgs();
        for (int r = 16; r < 20; r++) begin
            init_img[r] = 10'h3FF;
        end
        init_img[15] = 10'h201;
        exp_img[19]  = 10'h201;
        load_board();
        run_pass("s3", 0, 0);
        check_val("s3_done_off", last_off, 441);
        check_val("s3_lines", int'(lines_cleared), 4);
        check_val("s3_writes", wr_cnt, 200);
        check_board("s3");

        // 4: full row in the middle, nearly-full rows below stay put
        clear_imgs();
        for (int r = 11; r < 20; r++) begin
            init_img[r] = 10'h3FF ^ (10'h001 << (r - 10));
            exp_img[r]  = init_img[r];
        end
        init_img[10] = 10'h3FF;
        init_img[9]  = 10'h2A5;
        init_img[8]  = 10'h0F0;
        exp_img[10]  = 10'h2A5;
        exp_img[9]   = 10'h0F0;
        load_board();
        run_pass("s4", 0, 0);
        check_val("s4_done_off", last_off, 351);
        check_val("s4_lines", int'(lines_cleared), 1);
        check_val("s4_writes", wr_cnt, 110);
        check_val("s4_rows_below_written", int'(wr_rows[19:11]), 0);
        check_board("s4");

        // 5: scenario 2 with start re-pulsed while busy
        clear_imgs();
        init_img[19] = 10'h3FF;
        init_img[18] = 10'h01F;
        exp_img[19]  = 10'h01F;
        load_board();
        run_pass("s5", 5, 300);
        check_val("s5_done_off", last_off, 441);
        check_val("s5_lines", int'(lines_cleared), 1);
        check_board("s5");

        // 6: reset during the first copy of scenario 2
        clear_imgs();
        init_img[19] = 10'h3FF;
        init_img[18] = 10'h01F;
        load_board();
        tick();
        start = 1'b1;
        tick();
        start = 1'b0;
        for (int i = 0; i < 400 && wr_cnt < 3; i++) begin
            tick();
        end
        check_val("s6_in_copy", int'(board_we), 1);
        resetn = 1'b0;
        tick();
        check_val("s6_rst_busy", int'(busy), 0);
        check_val("s6_rst_we", int'(board_we), 0);
        check_val("s6_rst_lines", int'(lines_cleared), 0);
        resetn = 1'b1;
        repeat (20) tick();
        check_val("s6_no_done", done_cnt, 0);
        check_val("s6_idle_busy", int'(busy), 0);
        clear_imgs();
        load_board();
        run_pass("s6b", 0, 0);
        check_val("s6b_done_off", last_off, 241);
        check_val("s6b_lines", int'(lines_cleared), 0);
        check_val("s6b_writes", wr_cnt, 0);

        // 7: every row full, maximum clear count
        clear_imgs();
        for (int r = 0; r < ROWS; r++) begin
            init_img[r] = 10'h3FF;
        end
        load_board();
        run_pass("s7", 0, 0);
        check_val("s7_done_off", last_off, 441);
        check_val("s7_lines", int'(lines_cleared), 20);
        check_val("s7_writes", wr_cnt, 200);
        check_board("s7");

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/board_clear_ctrl.md
Name: board_clear_ctrl

Overview:
Line-clear sequencer for the 10x20 one-bit board memory. It runs after the game FSM finishes writing a locked piece, and the game FSM holds off spawning until `done`.
- Scans rows bottom-up (row 19 to row 0), removes every full row and compacts the surviving rows downward.
- Zero-fills the vacated top rows and reports how many lines were cleared.
- Owns the board read/write port while `busy` is high; the top level muxes the board port onto this block whenever `busy` = 1.

Parameters:
- COLS, 10, board width in cells (columns 0..COLS-1).
- ROWS, 20, board height in cells (rows 0..ROWS-1, row 0 at top).
- RD_LAT, 1, board read latency in cycles, from address presented to `board_rdata` valid; legal values 1 or 2.

Ports:
- CLOCK_50  input  1  system clock; all logic on its rising edge.
- resetn  input  1  synchronous, active-low reset.
- start  input  1  one-cycle request to begin a clear pass; sampled only in IDLE.
- busy  output  1  high while state != IDLE.
- done  output  1  one-cycle pulse when the pass completes.
- lines_cleared  output  5  number of full rows removed by the last pass; held until the next accepted start.
- board_rx  output  4  read column address.
- board_ry  output  5  read row address.
- board_rdata  input  1  cell value for the address presented RD_LAT cycles earlier.
- board_we  output  1  write enable; one cell per cycle.
- board_wx  output  4  write column.
- board_wy  output  5  write row.
- board_wdata  output  1  write value.

Behaviour:
- Reset values: state IDLE; busy 0; done 0; lines_cleared 0; board_we 0; all address outputs and board_wdata 0; src = dst = ROWS-1; row buffer cleared.
- Registers:
  - src: 6-bit signed row being read.
  - dst: 6-bit signed row being written.
  - col: column counter.
  - rowbuf: COLS-bit row buffer.
  - cnt: 5-bit clear counter.
- IDLE:
  - On start = 1: src <= ROWS-1, dst <= ROWS-1, cnt <= 0, lines_cleared <= 0, go to READ.
  - start in any other state is ignored.
- READ, lasting exactly COLS+RD_LAT cycles:
  - Issue address (col, src) on read cycles 0..COLS-1; board_rx/board_ry hold the last address afterwards.
  - The cell read on cycle k is captured into rowbuf[k] on cycle k+RD_LAT.
  - Then go to EVAL.
- EVAL, 1 cycle:
  - If rowbuf is all ones: cnt <= cnt+1, src <= src-1, dst unchanged.
  - Else if src != dst: go to COPY.
  - Else: src <= src-1, dst <= dst-1.
  - Next state:
    - COPY if the copy case was taken.
    - Otherwise READ if the new src >= 0.
    - Otherwise FILL if dst >= 0 and cnt > 0.
    - Otherwise DONE.
- COPY, exactly COLS cycles:
  - board_we = 1, board_wx = col, board_wy = dst, board_wdata = rowbuf[col], for col = 0..COLS-1.
  - On the last cycle: src <= src-1, dst <= dst-1.
  - Then READ if src-1 >= 0, else FILL (a copy implies cnt > 0).
- FILL:
  - For each row from dst down to 0, write COLS cells of 0 (COLS cycles per row, columns 0..COLS-1), decrementing dst after each row.
  - After row 0, go to DONE.
- DONE, 1 cycle: done = 1, lines_cleared <= cnt, then go to IDLE.
- board_we is 0 in every state except COPY and FILL; exactly one cell is written per cycle.
- Width rules:
  - src and dst are signed so that decrementing past row 0 yields -1 without wrapping.
  - Address outputs are the low 5 bits, only while the value is >= 0.
  - cnt max is ROWS (20) and fits in 5 bits.
- Latency:
  - Pass with no clears: ROWS*(COLS+RD_LAT+1) cycles in READ/EVAL, plus 1 in DONE.
  - Each surviving row below a cleared row adds COLS cycles (COPY).
  - Each cleared line adds COLS cycles (FILL).
- Reset mid-pass: returns to IDLE immediately with all outputs at reset values. Board contents may be partially compacted; the game FSM reinitialises the board after reset.

Test Plan:
1. Empty board, RD_LAT = 1, start pulse at cycle T:
   - busy = 1 from T+1.
   - board_we never asserted.
   - done = 1 at exactly T+241.
   - lines_cleared = 0.
   - busy = 0 at T+242.
2. Row 19 full, row 18 = 0b0000011111, other rows empty, start:
   - Row 19 = 0b0000011111 and row 18 = 0; the remaining empty rows shift down one and row 0 is zero-filled.
   - lines_cleared = 1.
   - done at T+1+240+19*10+10.
3. Rows 16..19 full, row 15 = 0b1000000001, start:
   - Row 19 = 0b1000000001; rows 0..18 = 0.
   - lines_cleared = 4.
   - Exactly 16*10+4*10 = 200 write cycles observed.
4. Row 10 full, row 9 pattern P, rows 11..19 non-full patterns:
   - Rows 11..19 unchanged and never written.
   - Row 10 = P, row 0 = 0.
   - lines_cleared = 1.
5. start re-pulsed while busy:
   - Ignored; single done.
   - Result identical to scenario 2.
6. resetn deasserted during COPY of scenario 2:
   - Next cycle: busy = 0, board_we = 0, lines_cleared = 0, done never pulses.
   - A following start on a re-initialised empty board behaves as scenario 1.
